// File: rtl/ram_init_engine.sv
// RAM initializer: sweeps a wrapping address range [base_addr..last_addr] modulo DEPTH,
// writing one word per clock with an identity, constant, reverse or offset pattern.
module ram_init_engine #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] ram_in,
  output logic              busy,
  output logic              finished
);

  localparam int unsigned       CMP_W    = ADDR_W + 1;
  localparam logic [CMP_W-1:0]  DEPTH_C  = CMP_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t              state, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic                we_d, busy_d, fin_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;
  logic                in_range_c;
  logic [ADDR_W-1:0]   next_addr_c;

  // Write data for address a under pattern m; arithmetic is done 32 bits wide then truncated.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] f);
    logic [31:0]       a32;
    logic [DATA_W-1:0] r;
    a32 = 32'(a);
    case (m)
      2'b00:   r = DATA_W'(a32);
      2'b01:   r = f;
      2'b10:   r = DATA_W'(32'(DEPTH - 1) - a32);
      default: r = DATA_W'(a32 + 32'(f));
    endcase
    return r;
  endfunction

  assign in_range_c  = ({1'b0, base_addr} < DEPTH_C) && ({1'b0, last_addr} < DEPTH_C);
  assign next_addr_c = (address == LAST_IDX) ? '0 : address + ADDR_W'(1);

  // Next-state and next-output logic; the address register doubles as the sweep counter.
  always_comb begin
    state_d = state;
    mode_d  = mode_q;
    fill_d  = fill_q;
    last_d  = last_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    fin_d   = 1'b0;
    addr_d  = address;
    data_d  = ram_in;
    case (state)
      IDLE: begin
        if (start && !abort && in_range_c) begin
          state_d = WRITE;
          mode_d  = mode;
          fill_d  = fill_value;
          last_d  = last_addr;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          addr_d  = base_addr;
          data_d  = pattern(mode, base_addr, fill_value);
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (address == last_q) begin
          state_d = DONE;
          fin_d   = 1'b1;
        end else begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          addr_d = next_addr_c;
          data_d = pattern(mode_q, next_addr_c, fill_q);
        end
      end
      DONE: begin
        if (start) begin
          fin_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mode_q       <= '0;
      fill_q       <= '0;
      last_q       <= '0;
      write_enable <= 1'b0;
      address      <= '0;
      ram_in       <= '0;
      busy         <= 1'b0;
      finished     <= 1'b0;
    end else begin
      state        <= state_d;
      mode_q       <= mode_d;
      fill_q       <= fill_d;
      last_q       <= last_d;
      write_enable <= we_d;
      address      <= addr_d;
      ram_in       <= data_d;
      busy         <= busy_d;
      finished     <= fin_d;
    end
  end

endmodule

// File: tb/tb_ram_init_engine.sv
// Bench for ram_init_engine: directed and random sweeps on a DEPTH=256 and a DEPTH=200 instance.
module tb_ram_init_engine;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          abort;
  logic [1:0]    mode;
  logic [DW-1:0] fill_value;
  logic          start1, start2;
  logic [AW-1:0] base1, last1, base2, last2;
  logic          we1, busy1, fin1, we2, busy2, fin2;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] data1, data2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_init_engine #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(256)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort), .mode(mode),
    .fill_value(fill_value), .base_addr(base1), .last_addr(last1),
    .write_enable(we1), .address(addr1), .ram_in(data1), .busy(busy1), .finished(fin1)
  );

  ram_init_engine #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(200)) u_dut200 (
    .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort), .mode(mode),
    .fill_value(fill_value), .base_addr(base2), .last_addr(last2),
    .write_enable(we2), .address(addr2), .ram_in(data2), .busy(busy2), .finished(fin2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pattern, straight from the mode definitions.
  function automatic int exp_data(input int depth, input int m, input int a, input int f);
    case (m)
      0:       return a % 256;
      1:       return f;
      2:       return (depth - 1 - a) % 256;
      default: return (a + f) % 256;
    endcase
  endfunction

  task automatic obs(input int sel, output logic we, output logic [AW-1:0] a,
                     output logic [DW-1:0] d, output logic bz, output logic fn);
    if (sel == 0) begin we = we1; a = addr1; d = data1; bz = busy1; fn = fin1; end
    else          begin we = we2; a = addr2; d = data2; bz = busy2; fn = fin2; end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start1 = v; else start2 = v;
  endtask

  // Full sweep: every cycle must carry the next expected word, then DONE handshake.
  task automatic sweep(input int sel, input int m, input int f, input int b, input int l,
                       input string tag);
    int depth, n, a;
    logic we, bz, fn;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    depth = (sel == 0) ? 256 : 200;
    n = ((l - b + depth) % depth) + 1;
    mode = 2'(m);
    fill_value = DW'(f);
    if (sel == 0) begin base1 = AW'(b); last1 = AW'(l); end
    else          begin base2 = AW'(b); last2 = AW'(l); end
    set_start(sel, 1'b1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      a = (b + i) % depth;
      obs(sel, we, ad, d, bz, fn);
      check({tag, "_we"}, 32'(we), 32'd1);
      check({tag, "_addr"}, 32'(ad), 32'(a));
      check({tag, "_data"}, 32'(d), 32'(exp_data(depth, m, a, f)));
      check({tag, "_busy"}, 32'(bz), 32'd1);
      check({tag, "_fin_low"}, 32'(fn), 32'd0);
      if (i == 0) begin
        // inputs must be ignored once the sweep is running
        mode = 2'($urandom);
        fill_value = DW'($urandom);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      obs(sel, we, ad, d, bz, fn);
      check({tag, "_done_we"}, 32'(we), 32'd0);
      check({tag, "_done_fin"}, 32'(fn), 32'd1);
      check({tag, "_done_busy"}, 32'(bz), 32'd0);
    end
    set_start(sel, 1'b0);
    @(posedge clk); #1;
    obs(sel, we, ad, d, bz, fn);
    check({tag, "_fin_clear"}, 32'(fn), 32'd0);
    check({tag, "_idle_we"}, 32'(we), 32'd0);
  endtask

  task automatic expect_quiet(input int sel, input int cycles, input string tag);
    logic we, bz, fn;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      obs(sel, we, ad, d, bz, fn);
      check({tag, "_we"}, 32'(we), 32'd0);
      check({tag, "_busy"}, 32'(bz), 32'd0);
      check({tag, "_fin"}, 32'(fn), 32'd0);
    end
  endtask

  initial begin
    int b, l;
    reset_n = 1'b0;
    abort = 1'b0; mode = 2'b00; fill_value = '0;
    start1 = 1'b0; start2 = 1'b0;
    base1 = '0; last1 = '0; base2 = '0; last2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(we1), 32'd0);
    check("rst_addr", 32'(addr1), 32'd0);
    check("rst_data", 32'(data1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_fin", 32'(fin1), 32'd0);
    check("rst_we200", 32'(we2), 32'd0);
    reset_n = 1'b1;
    expect_quiet(0, 2, "idle");

    sweep(0, 0, 0, 0, 255, "full_ident");
    sweep(0, 1, 8'hA5, 16, 31, "const_a");
    sweep(0, 1, 8'hA5, 16, 31, "const_b");
    sweep(0, 3, 8'h03, 250, 4, "offset_wrap");
    sweep(0, 2, 0, 0, 255, "reverse");
    sweep(0, 1, 8'h77, 77, 77, "single");

    // Abort on the 50th write of a full identity sweep
    mode = 2'b00; base1 = 8'd0; last1 = 8'd255; start1 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("abort_pre_addr", 32'(addr1), 32'(i));
    end
    abort = 1'b1; start1 = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_we", 32'(we1), 32'd0);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_fin", 32'(fin1), 32'd0);
    check("abort_addr_hold", 32'(addr1), 32'd49);
    expect_quiet(0, 3, "post_abort");
    sweep(0, 0, 0, 0, 9, "restart");

    // Abort together with start in IDLE: no sweep
    abort = 1'b1; start1 = 1'b1;
    expect_quiet(0, 2, "abort_start");
    abort = 1'b0; start1 = 1'b0;
    @(posedge clk); #1;

    // Async reset mid-sweep at address 100
    mode = 2'b00; base1 = 8'd0; last1 = 8'd255; start1 = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_addr", 32'(addr1), 32'd100);
    reset_n = 1'b0; start1 = 1'b0;
    #1;
    check("arst_we", 32'(we1), 32'd0);
    check("arst_addr", 32'(addr1), 32'd0);
    check("arst_data", 32'(data1), 32'd0);
    check("arst_busy", 32'(busy1), 32'd0);
    check("arst_fin", 32'(fin1), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    expect_quiet(0, 3, "post_rst");

    // Out-of-range requests on the DEPTH=200 instance
    base2 = 8'd0; last2 = 8'd210; start2 = 1'b1;
    expect_quiet(1, 4, "range_last");
    start2 = 1'b0;
    @(posedge clk); #1;
    base2 = 8'd200; last2 = 8'd5; start2 = 1'b1;
    expect_quiet(1, 4, "range_base");
    start2 = 1'b0;
    @(posedge clk); #1;
    sweep(1, 2, 0, 190, 9, "rev200_wrap");

    // Random sweeps on both instances
    for (int k = 0; k < 6; k++) begin
      b = int'($urandom_range(0, 255));
      l = int'($urandom_range(0, 255));
      sweep(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), b, l, "rand256");
      b = int'($urandom_range(0, 199));
      l = int'($urandom_range(0, 199));
      sweep(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), b, l, "rand200");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_init_engine.md
Name: ram_init_engine

Overview:
Parametrised successor to the single-mode RAM initializer in the RC4 decryption datapath. On a start request it sweeps a configurable address range of the S-box/working RAM, writing one word per clock with a pattern chosen by a mode input: identity, constant fill, reverse, or offset. Handshake is start/finished, with a busy flag and abort. The sweep controller ahead of the KSA stage uses it to reset S[] and to clear scratch RAMs between key attempts.

Parameters:
ADDR_W, 8, address width in bits
DATA_W, 8, RAM word width in bits
DEPTH, 256, number of addressable words; legal range 2..2**ADDR_W

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  level request; a sweep begins on a rising level seen in IDLE
abort  input  1  terminate the sweep at the next edge
mode  input  2  pattern: 00 identity, 01 constant, 10 reverse, 11 offset
fill_value  input  DATA_W  constant for mode 01; offset for mode 11
base_addr  input  ADDR_W  first address written
last_addr  input  ADDR_W  final address written, inclusive
write_enable  output  1  RAM write strobe
address  output  ADDR_W  RAM write address
ram_in  output  DATA_W  RAM write data
busy  output  1  high while in WRITE
finished  output  1  sweep-complete flag

Behaviour:
- All outputs are registered. On reset_n=0, asynchronously: state=IDLE, write_enable=0, address=0, ram_in=0, busy=0, finished=0.
- FSM states: IDLE, WRITE, DONE.
- IDLE, start=1 at an edge:
  - latch mode, fill_value, base_addr and last_addr;
  - set the counter to base_addr;
  - go to WRITE.
  - The first write (write_enable=1, address=base_addr) is visible the cycle after the edge that sampled start. Inputs are ignored until the next IDLE.
- WRITE: one word per cycle, addr = counter.
  - Data per mode (addr zero-extended or truncated to DATA_W):
    - 00: ram_in = addr
    - 01: ram_in = fill_value
    - 10: ram_in = (DEPTH-1-addr) mod 2**DATA_W
    - 11: ram_in = (addr + fill_value) mod 2**DATA_W
  - When counter == latched last_addr, that write is the final one; next state is DONE.
- Wrap-around:
  - if last_addr < base_addr, the counter wraps from DEPTH-1 to 0 and continues to last_addr;
  - counter increments modulo DEPTH, not 2**ADDR_W;
  - base_addr == last_addr writes exactly one word.
- Range: if base_addr or last_addr is ≥ DEPTH, the start request is ignored and the FSM stays in IDLE with no writes.
- Write count: ((last_addr - base_addr) mod DEPTH) + 1. A full sweep of base 0 to last DEPTH-1 takes DEPTH cycles.
- DONE: write_enable=0, busy=0, finished=1. finished stays high while start=1. When start=0 at an edge, finished clears and the state returns to IDLE.
  - A new sweep therefore needs start deasserted, then reasserted.
  - start held high across completion does not retrigger.
- abort=1 at an edge in WRITE:
  - next state is IDLE; write_enable=0 and busy=0 from that edge;
  - no finished pulse;
  - a write already presented in that cycle completes.
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: abort wins, no sweep starts.
- While write_enable=0, address and ram_in hold their last values.
- An asynchronous reset mid-sweep returns the FSM to IDLE immediately. No further writes occur and finished stays 0.

Test Plan:
- Defaults, mode 00, base 0, last 255, start held high: 256 consecutive writes with ram_in==address for 0..255. finished rises the cycle after address 255, busy is low in DONE, and there is no retrigger while start stays high.
- Mode 01, fill_value 8'hA5, base 16, last 31: exactly 16 writes to addresses 16..31, all with data 8'hA5. Deassert start: finished=0 next cycle. Reassert start: a second identical sweep runs.
- Mode 11, fill 8'h03, base 250, last 4: 11 writes with addresses 250..255 then 0..4 and data = address+3 mod 256, so the write to 255 carries 8'h02. Also mode 10, base 0, last 255: write to 0 carries 255, write to 255 carries 0.
- Abort at the 50th write of a full mode-00 sweep: write_enable=0 from the next edge, finished never rises, and the FSM accepts a new start afterwards.
- Assert reset_n=0 mid-sweep at address 100: all outputs clear asynchronously. With DEPTH=200, a start with last_addr=210 is ignored (no writes, finished=0).
